// File: rtl/matrixmult_pkg.sv
// rtl/matrixmult_pkg.sv - shared widths, clog2 helper and requester-ID type for the MatrixMult datapath

package matrixmult_pkg;

  localparam int DEF_DIN0_W = 16;
  localparam int DEF_DIN1_W = 14;
  localparam int DEF_DOUT_W = DEF_DIN0_W + DEF_DIN1_W;
  localparam int DEF_ID_W   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [DEF_ID_W-1:0] req_id_t;

endpackage

// File: rtl/matrixmult_mul_arbiter_if.sv
// rtl/matrixmult_mul_arbiter_if.sv - requester and response handshake bundle of the shared multiplier

interface matrixmult_mul_arbiter_if
  import matrixmult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIN0_W  = DEF_DIN0_W,
  parameter int DIN1_W  = DEF_DIN1_W,
  parameter int DOUT_W  = DEF_DOUT_W,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DIN0_W-1:0] req_din0;
  logic [NUM_REQ*DIN1_W-1:0] req_din1;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DOUT_W-1:0]         rsp_dout;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_dout, rsp_id
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_dout, rsp_id
  );

endinterface

// File: rtl/matrixmult_mul_pipe.sv
// rtl/matrixmult_mul_pipe.sv - unsigned multiplier with LAT clock-enabled register stages, no reset

module matrixmult_mul_pipe
  import matrixmult_pkg::*;
#(
  parameter int A_W = DEF_DIN0_W,
  parameter int B_W = DEF_DIN1_W,
  parameter int P_W = DEF_DOUT_W,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic [P_W-1:0] stage [LAT];

  // Data stages carry no reset; the shadow valid pipe masks stale contents.
  always_ff @(posedge clk) begin
    if (ce) begin
      stage[0] <= P_W'(a) * P_W'(b);
      for (int i = 1; i < LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign p = stage[LAT-1];

endmodule

// File: rtl/matrixmult_mul_arbiter.sv
// rtl/matrixmult_mul_arbiter.sv - round-robin share of one pipelined multiplier among NUM_REQ lanes

module matrixmult_mul_arbiter
  import matrixmult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIN0_W  = DEF_DIN0_W,
  parameter int DIN1_W  = DEF_DIN1_W,
  parameter int DOUT_W  = DEF_DOUT_W,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                     clk,
  input  logic                     reset,
  matrixmult_mul_arbiter_if.slave  bus,
  output logic                     busy,
  output logic [31:0]              issue_cnt
);

  localparam int SEL_W = clog2(NUM_REQ);

  logic               ce;
  logic               accept;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W:0]     sum;
  logic [SEL_W-1:0]   rr_ptr;
  logic [MUL_LAT-1:0] v;
  logic [ID_W-1:0]    id_pipe [MUL_LAT];
  logic [DIN0_W-1:0]  mul_a;
  logic [DIN1_W-1:0]  mul_b;
  logic [DOUT_W-1:0]  mul_out;

  // Freeze only when the last stage holds a product nobody is taking.
  assign ce = !(v[MUL_LAT-1] && !bus.rsp_ready);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_REQ)) sum = sum - (SEL_W+1)'(NUM_REQ);
      cand = sum[SEL_W-1:0];
      if (!grant_valid && bus.req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept        = ce && grant_valid;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign mul_a = bus.req_din0[grant_idx*DIN0_W +: DIN0_W];
  assign mul_b = bus.req_din1[grant_idx*DIN1_W +: DIN1_W];

  matrixmult_mul_pipe #(
    .A_W (DIN0_W),
    .B_W (DIN1_W),
    .P_W (DOUT_W),
    .LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .ce  (ce),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        id_pipe[i] <= '0;
      end
    end else if (ce) begin
      v[0]       <= accept;
      id_pipe[0] <= ID_W'(grant_idx);
      for (int i = 1; i < MUL_LAT; i++) begin
        v[i]       <= v[i-1];
        id_pipe[i] <= id_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      issue_cnt <= '0;
    end else if (accept) begin
      rr_ptr    <= (grant_idx == SEL_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      issue_cnt <= issue_cnt + 32'd1;
    end
  end

  assign bus.rsp_valid = v[MUL_LAT-1];
  assign bus.rsp_dout  = v[MUL_LAT-1] ? mul_out : '0;
  assign bus.rsp_id    = v[MUL_LAT-1] ? id_pipe[MUL_LAT-1] : '0;
  assign busy          = |v;

endmodule

// File: tb/tb_matrixmult_mul_arbiter.sv
// tb/tb_matrixmult_mul_arbiter.sv - directed self-checking bench for the shared multiplier arbiter

module tb_matrixmult_mul_arbiter;
  import matrixmult_pkg::*;

  localparam int NR  = 4;
  localparam int A_W = 16;
  localparam int B_W = 14;
  localparam int P_W = 30;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [31:0] issue_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  matrixmult_mul_arbiter_if #(
    .NUM_REQ(NR), .DIN0_W(A_W), .DIN1_W(B_W), .DOUT_W(P_W), .ID_W(IDW)
  ) bus ();

  matrixmult_mul_arbiter #(
    .NUM_REQ(NR), .DIN0_W(A_W), .DIN1_W(B_W), .DOUT_W(P_W), .MUL_LAT(LAT), .ID_W(IDW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  // Requester contract: a pending request keeps valid and operands until accepted.
  logic [NR-1:0]     pend = '0;
  logic [NR*A_W-1:0] pa;
  logic [NR*B_W-1:0] pb;
  always @(posedge clk) begin
    if (reset) begin
      pend = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && (!bus.req_valid[i] || bus.req_din0[i*A_W +: A_W] !== pa[i*A_W +: A_W]
                        || bus.req_din1[i*B_W +: B_W] !== pb[i*B_W +: B_W])) begin
          errors++;
          $display("FAIL contract req%0d dropped or changed while pending", i);
        end
      end
      pend = bus.req_valid & ~bus.req_ready;
      pa   = bus.req_din0;
      pb   = bus.req_din1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    bus.req_din0[i*A_W +: A_W] = a;
    bus.req_din1[i*B_W +: B_W] = b;
  endtask

  task automatic reset_dut;
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [A_W-1:0] bp_a(input int i, input int d);
    return A_W'(40 + 13*i + 7*d);
  endfunction

  function automatic logic [B_W-1:0] bp_b(input int i, input int d);
    return B_W'(9 + 5*i + 3*d);
  endfunction

  function automatic logic [P_W-1:0] rr_prod(input int i);
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    a = A_W'(1000*(i+1) + 7);
    b = B_W'(50*(i+1) + 3);
    return P_W'(a) * P_W'(b);
  endfunction

  task automatic test_reset;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'd0) begin errors++; $display("FAIL reset_rsp_dout got %0h exp 0", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    checks++; if (issue_cnt !== 32'd0) begin errors++; $display("FAIL reset_issue_cnt got %0d exp 0", issue_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bus.rsp_ready = 1'b1;
    set_op(1, 16'd3, 14'd4);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int c = 1; c < LAT; c++) begin
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      tick();
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'd12) begin errors++; $display("FAIL single_dout got %0d exp 12", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL single_id got %0d exp 1", bus.rsp_id); end
    checks++; if (issue_cnt !== 32'd1) begin errors++; $display("FAIL single_issue_cnt got %0d exp 1", issue_cnt); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'd0) begin errors++; $display("FAIL single_after_dout got %0d exp 0", bus.rsp_dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_after_busy got %b exp 0", busy); end
  endtask

  task automatic test_extremes;
    set_op(0, 16'hFFFF, 14'h3FFF);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL ext_ready got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (LAT - 1) tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL ext_valid got %b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'h3FFEC001) begin errors++; $display("FAIL ext_dout got %0h exp 3ffec001", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL ext_id got %0d exp 0", bus.rsp_id); end
    tick();
  endtask

  task automatic test_round_robin;
    int cnt [NR];
    int e;
    logic [NR-1:0] exp_ready;
    logic [P_W-1:0] exp_p;
    reset_dut();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      set_op(i, A_W'(1000*(i+1) + 7), B_W'(50*(i+1) + 3));
    end
    for (int n = 0; n < 100 + LAT; n++) begin
      for (int i = 0; i < NR; i++) bus.req_valid[i] = (cnt[i] < 25);
      #1;
      exp_ready = (n < 100) ? (NR'(1) << (n % NR)) : '0;
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant n=%0d got %b exp %b", n, bus.req_ready, exp_ready); end
      if (n >= LAT) begin
        e = (n - LAT) % NR;
        exp_p = rr_prod(e);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid n=%0d got %b exp 1", n, bus.rsp_valid); end
        checks++; if (bus.rsp_id !== IDW'(e)) begin errors++; $display("FAIL rr_id n=%0d got %0d exp %0d", n, bus.rsp_id, e); end
        checks++; if (bus.rsp_dout !== exp_p) begin errors++; $display("FAIL rr_dout n=%0d got %0d exp %0d", n, bus.rsp_dout, exp_p); end
      end
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) cnt[i]++;
      tick();
    end
    checks++; if (issue_cnt !== 32'd100) begin errors++; $display("FAIL rr_issue_cnt got %0d exp 100", issue_cnt); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (cnt[i] != 25) begin errors++; $display("FAIL rr_share req%0d got %0d exp 25", i, cnt[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    bit             mv [LAT];
    int             mid [LAT];
    logic [P_W-1:0] mp [LAT];
    int             done [NR];
    int             ptr, g, got, exp_got;
    logic           ce, exp_busy;
    logic [NR-1:0]  mask, exp_ready;
    req_id_t        exp_id;
    logic [P_W-1:0] exp_d;
    reset_dut();
    ptr = 0; got = 0; exp_got = 0;
    for (int s = 0; s < LAT; s++) begin mv[s] = 1'b0; mid[s] = 0; mp[s] = '0; end
    for (int i = 0; i < NR; i++) done[i] = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.rsp_ready = !(cyc >= 5 && cyc < 10);
      for (int i = 0; i < NR; i++) begin
        mask[i] = (done[i] < 2);
        set_op(i, bp_a(i, done[i]), bp_b(i, done[i]));
      end
      bus.req_valid = mask;
      #1;
      ce = !(mv[LAT-1] && !bus.rsp_ready);
      g = rr_pick(mask, ptr);
      exp_ready = (ce && g >= 0) ? (NR'(1) << g) : '0;
      exp_id = mv[LAT-1] ? req_id_t'(mid[LAT-1]) : '0;
      exp_d = mv[LAT-1] ? mp[LAT-1] : '0;
      exp_busy = 1'b0;
      for (int s = 0; s < LAT; s++) exp_busy |= mv[s];
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready cyc=%0d got %b exp %b", cyc, bus.req_ready, exp_ready); end
      checks++; if (bus.rsp_valid !== mv[LAT-1]) begin errors++; $display("FAIL bp_valid cyc=%0d got %b exp %b", cyc, bus.rsp_valid, mv[LAT-1]); end
      checks++; if (bus.rsp_id !== exp_id) begin errors++; $display("FAIL bp_id cyc=%0d got %0d exp %0d", cyc, bus.rsp_id, exp_id); end
      checks++; if (bus.rsp_dout !== exp_d) begin errors++; $display("FAIL bp_dout cyc=%0d got %0d exp %0d", cyc, bus.rsp_dout, exp_d); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL bp_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy); end
      if (bus.rsp_valid && bus.rsp_ready) got++;
      if (mv[LAT-1] && bus.rsp_ready) exp_got++;
      if (ce) begin
        for (int s = LAT - 1; s > 0; s--) begin mv[s] = mv[s-1]; mid[s] = mid[s-1]; mp[s] = mp[s-1]; end
        mv[0] = (g >= 0);
        if (g >= 0) begin
          mid[0] = g;
          mp[0] = P_W'(bp_a(g, done[g])) * P_W'(bp_b(g, done[g]));
          done[g]++;
          ptr = (g + 1) % NR;
        end
      end
      tick();
    end
    checks++; if (got != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got); end
    checks++; if (got != exp_got) begin errors++; $display("FAIL bp_model_count got %0d exp %0d", got, exp_got); end
    checks++; if (issue_cnt !== 32'd8) begin errors++; $display("FAIL bp_issue_cnt got %0d exp 8", issue_cnt); end
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_reset_midflight;
    reset_dut();
    bus.rsp_ready = 1'b1;
    set_op(0, 16'd5, 14'd6);
    bus.req_valid = 4'b0001;
    tick();
    set_op(1, 16'd7, 14'd8);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'd30) begin errors++; $display("FAIL rst_pre_dout got %0d exp 30", bus.rsp_dout); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_dout !== 30'd0) begin errors++; $display("FAIL rst_async_dout got %0d exp 0", bus.rsp_dout); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rst_async_id got %0d exp 0", bus.rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", busy); end
    checks++; if (issue_cnt !== 32'd0) begin errors++; $display("FAIL rst_async_issue_cnt got %0d exp 0", issue_cnt); end
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_valid c=%0d got %b exp 0", c, bus.rsp_valid); end
      tick();
    end
    set_op(0, 16'd2, 14'd3);
    set_op(3, 16'd4, 14'd5);
    bus.req_valid = 4'b1001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rst_second_grant got %b exp 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (LAT) tick();
    checks++; if (issue_cnt !== 32'd2) begin errors++; $display("FAIL rst_issue_cnt got %0d exp 2", issue_cnt); end
  endtask

  task automatic test_sparse;
    int ph;
    logic [NR-1:0] exp_ready;
    logic [P_W-1:0] exp_p;
    reset_dut();
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ph = cyc % 3;
      if (ph == 0) set_op(2, A_W'(cyc + 1), B_W'(cyc + 2));
      bus.req_valid = (ph == 0) ? 4'b0100 : 4'b0000;
      #1;
      exp_ready = (ph == 0) ? 4'b0100 : 4'b0000;
      exp_p = P_W'(cyc - 1) * P_W'(cyc);
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL sparse_ready cyc=%0d got %b exp %b", cyc, bus.req_ready, exp_ready); end
      checks++; if (busy !== (ph != 0)) begin errors++; $display("FAIL sparse_busy cyc=%0d got %b exp %b", cyc, busy, ph != 0); end
      checks++; if (bus.rsp_valid !== (ph == 2)) begin errors++; $display("FAIL sparse_valid cyc=%0d got %b exp %b", cyc, bus.rsp_valid, ph == 2); end
      if (ph == 2) begin
        checks++; if (bus.rsp_dout !== exp_p) begin errors++; $display("FAIL sparse_dout cyc=%0d got %0d exp %0d", cyc, bus.rsp_dout, exp_p); end
        checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL sparse_id cyc=%0d got %0d exp 2", cyc, bus.rsp_id); end
      end
      tick();
    end
    set_op(0, 16'd9, 14'd9);
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL sparse_ptr_wrap got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL sparse_ptr_next got %b exp 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (LAT) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sparse_end_busy got %b exp 0", busy); end
    checks++; if (issue_cnt !== 32'd6) begin errors++; $display("FAIL sparse_issue_cnt got %0d exp 6", issue_cnt); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_sparse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
